// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller.
// Turns one load/store into a single word-aligned bus transaction, formats
// store lanes and byte enables, extends load data, and pulses mem_access_done
// once per access (completed, misaligned/illegal, or timed out).
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   sdram_init_done     : no request is issued while low
//   mem_valid/we/funct3 : MEM-stage load/store command (RV32I width/sign field)
//   mem_addr/mem_wdata  : byte address and store data
//   mem_access_done     : one-cycle completion pulse
//   mem_rdata           : extended load data, valid with done
//   misalign_err        : with done, misaligned or illegal access (no bus cycle)
//   bus_err             : with done, bus_ack timeout
//   bus_req/we/addr/be/wdata : registered bus request fields
//   bus_ack/bus_rdata   : slave acknowledge and read word
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_init_done,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_access_done,
    output logic [31:0] mem_rdata,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_skip, w_skip_nxt;
    logic [2:0]        r_f3, w_f3_nxt;
    logic [1:0]        r_off, w_off_nxt;
    logic              r_done, w_done_nxt;
    logic [31:0]       r_rdata, w_rdata_nxt;
    logic              r_mis, w_mis_nxt;
    logic              r_berr, w_berr_nxt;
    logic              r_req, w_req_nxt;
    logic              r_we, w_we_nxt;
    logic [31:0]       r_addr, w_addr_nxt;
    logic [3:0]        r_be, w_be_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;

    logic              w_legal, w_aligned;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_shift;
    logic [31:0]       w_ld_fmt;

    // Decode of the incoming command: legality, alignment, lanes
    always_comb begin
        w_legal   = 1'b0;
        w_aligned = 1'b1;
        w_be      = 4'b1111;
        w_wdata   = mem_wdata;
        case (mem_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !mem_we;
            default:                w_legal = 1'b0;
        endcase
        case (mem_funct3[1:0])
            2'b01:   w_aligned = !mem_addr[0];
            2'b10:   w_aligned = (mem_addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
        if (mem_we) begin
            case (mem_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << mem_addr[1:0];
                    w_wdata = {4{mem_wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {mem_addr[1], 1'b0};
                    w_wdata = {2{mem_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = mem_wdata;
                end
            endcase
        end
    end

    // Load extraction from the latched width/offset
    always_comb begin
        w_shift = bus_rdata >> {r_off, 3'b000};
        case (r_f3)
            3'b000:  w_ld_fmt = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_ld_fmt = {24'h000000, w_shift[7:0]};
            3'b001:  w_ld_fmt = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b101:  w_ld_fmt = {16'h0000, w_shift[15:0]};
            default: w_ld_fmt = bus_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_skip_nxt  = 1'b0;
        w_f3_nxt    = r_f3;
        w_off_nxt   = r_off;
        w_done_nxt  = 1'b0;
        w_rdata_nxt = 32'h0;
        w_mis_nxt   = 1'b0;
        w_berr_nxt  = 1'b0;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_be_nxt    = r_be;
        w_wdata_nxt = r_wdata;
        case (r_state)
            S_IDLE: begin
                // r_skip blocks a reissue while the pipeline advances past DONE
                if (mem_valid && sdram_init_done && !r_skip) begin
                    if (w_legal && w_aligned) begin
                        w_f3_nxt    = mem_funct3;
                        w_off_nxt   = mem_addr[1:0];
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = mem_we;
                        w_addr_nxt  = {mem_addr[31:2], 2'b00};
                        w_be_nxt    = w_be;
                        w_wdata_nxt = w_wdata;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_BUSY;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_mis_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                // Ack wins over a timeout landing in the same cycle
                if (bus_ack) begin
                    w_req_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_rdata_nxt = r_we ? 32'h0 : w_ld_fmt;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_req_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_berr_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_skip_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_skip  <= 1'b0;
            r_f3    <= 3'b000;
            r_off   <= 2'b00;
            r_done  <= 1'b0;
            r_rdata <= 32'h0;
            r_mis   <= 1'b0;
            r_berr  <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_be    <= 4'h0;
            r_wdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_skip  <= w_skip_nxt;
            r_f3    <= w_f3_nxt;
            r_off   <= w_off_nxt;
            r_done  <= w_done_nxt;
            r_rdata <= w_rdata_nxt;
            r_mis   <= w_mis_nxt;
            r_berr  <= w_berr_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_be    <= w_be_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign mem_access_done = r_done;
    assign mem_rdata       = r_rdata;
    assign misalign_err    = r_mis;
    assign bus_err         = r_berr;
    assign bus_req         = r_req;
    assign bus_we          = r_we;
    assign bus_addr        = r_addr;
    assign bus_be          = r_be;
    assign bus_wdata       = r_wdata;

endmodule
